// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the scalar LoongArch pipeline.
//
// Owns the fetch PC and issues word fetches over a request/grant interface
// with in-order responses. Returned words are queued with their PCs in a
// small instruction FIFO that decode reads through a valid/stall handshake.
// A redirect (flush_i) empties the FIFO, reloads the PC and discards every
// response still in flight.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   stall_i                  decode cannot take the head entry this cycle
//   flush_i, redirect_pc_i   redirect request and new fetch PC
//   imem_req_o, imem_addr_o  fetch request and word-aligned address
//   imem_gnt_i               request accepted this cycle
//   imem_rvalid_i/rdata_i    in-order response valid and instruction word
//   inst_valid_o, pc_o, inst_o  FIFO head entry presented to decode
//   fetch_cnt_o              popped-instruction count (IFETCH_PERF_CNT_EN)
//
// Optional feature: define IFETCH_PERF_CNT_EN to add fetch_cnt_o.

module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h1C00_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o
`endif
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [31:0]      fetch_pc;
   logic [CNT_W-1:0] outstanding, outstanding_nxt;
   logic [CNT_W-1:0] drop_cnt, drop_nxt;

   // Tag FIFO: granted addresses, one entry per outstanding request.
   logic [31:0]      tag_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] tag_rd_ptr, tag_wr_ptr;

   // Instruction FIFO.
   logic [31:0]      fifo_pc   [FIFO_DEPTH];
   logic [31:0]      fifo_inst [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] fifo_cnt;

   // Last head values shown, so outputs hold while the FIFO is empty.
   logic [31:0]      hold_pc, hold_inst;

   logic [CNT_W:0]   credit_used;
   logic             gnt, resp, drop_resp, push, pop;
   logic             unused_redirect;

   assign unused_redirect = ^redirect_pc_i[1:0];

   // Credits are judged on registered counts only, so the request stays
   // stable until granted: a push is always paired with an outstanding
   // decrement and a pop only frees credit.
   assign credit_used = {1'b0, outstanding} + {1'b0, fifo_cnt};
   assign imem_req_o  = (state == RUN) && (credit_used < DEPTH_LIM);
   assign imem_addr_o = fetch_pc;

   assign gnt       = imem_req_o & imem_gnt_i;
   assign resp      = imem_rvalid_i & (outstanding != '0);
   assign drop_resp = resp & (drop_cnt != '0);

   assign inst_valid_o = (fifo_cnt != '0);
   assign pop          = inst_valid_o & ~stall_i & ~flush_i;
   assign push         = resp & ~drop_resp & ~flush_i;

   assign pc_o   = inst_valid_o ? fifo_pc[rd_ptr]   : hold_pc;
   assign inst_o = inst_valid_o ? fifo_inst[rd_ptr] : hold_inst;

   assign outstanding_nxt = outstanding + CNT_W'(gnt) - CNT_W'(resp);

   always_comb begin
      drop_nxt = drop_cnt;
      if (flush_i) begin
         // Everything still in flight after this cycle belongs to the old path.
         drop_nxt = outstanding_nxt;
      end else if (drop_resp) begin
         drop_nxt = drop_cnt - CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     state_nxt = RUN;
         DRAIN:   if (drop_nxt == '0) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
      if (flush_i) begin
         state_nxt = (drop_nxt == '0) ? RUN : DRAIN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         tag_rd_ptr  <= '0;
         tag_wr_ptr  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_cnt    <= '0;
         hold_pc     <= '0;
         hold_inst   <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_nxt;

         // Tag pointers advance even across a flush: dropped responses still
         // consume their tag.
         if (gnt)  tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
         if (resp) tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);

         if (flush_i) begin
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
         end else if (gnt) begin
            fetch_pc <= fetch_pc + 32'd4;
         end

         if (inst_valid_o) begin
            hold_pc   <= fifo_pc[rd_ptr];
            hold_inst <= fifo_inst[rd_ptr];
         end

         if (flush_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Storage arrays carry no reset; validity is tracked by the counters.
   always_ff @(posedge clk) begin
      if (gnt) begin
         tag_mem[tag_wr_ptr] <= fetch_pc;
      end
      if (push) begin
         fifo_pc[wr_ptr]   <= tag_mem[tag_rd_ptr];
         fifo_inst[wr_ptr] <= imem_rdata_i;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_o <= '0;
      end else if (pop) begin
         fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
   end
`endif

endmodule
